qed_sif_commit_tracker: RTL and testbench
=========================================

// Module: qed_sif_commit_tracker
// PURPOSE
// - Producer side of the QED commit-tracking interface: generates sif_commit, sif_commit_pulsed,
//   qed_check_valid, sif_state, qed_num_orig and qed_num_dup inside the dut for the formal checker.
// - On a commit request it holds fetch, drains the pipeline, marks commit point T_C with a 1-cycle
//   pulse, then counts retired original/duplicate instructions and flags when the check is valid.
// PARAMETERS
// - CNT_W      8  width of qed_num_orig / qed_num_dup (saturating)
// - INFL_W     4  width of in-flight instruction counter (max 2**INFL_W-1 in flight)
// PORTS
// - clk               in   1       clock
// - rst               in   1       synchronous, active-high reset
// - commit_req        in   1       request to establish a commit point (free input in formal)
// - issue_valid       in   1       one instruction enters the pipeline this cycle
// - retire_valid      in   1       one instruction retires this cycle
// - retire_dup        in   1       retiring instruction is a duplicate (rd in 16..31); valid with retire_valid
// - fetch_hold        out  1       stall instruction fetch (DRAIN state)
// - sif_state         out  2       FSM state: 0 IDLE, 1 DRAIN, 2 COMMIT, 3 TRACK
// - sif_commit        out  1       level: commit point has been taken (COMMIT or TRACK)
// - sif_commit_pulsed out  1       1-cycle pulse at T_C (COMMIT state)
// - qed_num_orig      out  CNT_W   originals retired since T_C
// - qed_num_dup       out  CNT_W   duplicates retired since T_C
// - qed_check_valid   out  1       orig/dup counts balanced, nonzero, pipeline empty
// - track_err         out  1       sticky: dup ran ahead of orig, counter saturated, or in-flight overflow
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; in-flight counter 0. Reset mid-operation aborts any state.
// - In-flight counter: +1 on issue_valid, -1 on retire_valid, unchanged on both; pipe_empty = (cnt==0).
//   Increment at max or decrement at 0: counter holds, track_err set.
// - FSM (registered; outputs decoded from state/registers, no comb path from inputs):
//   IDLE : commit_req -> DRAIN. Otherwise stay.
//   DRAIN: fetch_hold=1. If pipe_empty (this cycle, incl. retire this cycle leaving 0) -> COMMIT.
//          issue_valid while fetch_hold=1 is ignored for state but still counted.
//   COMMIT: exactly one cycle; sif_commit=1, sif_commit_pulsed=1, qed_num_orig/dup forced to 0; -> TRACK.
//   TRACK: sif_commit=1; stays until rst. commit_req ignored in COMMIT and TRACK.
// - Counting (TRACK only; retires in other states not counted): retire_valid&~retire_dup -> orig+1;
//   retire_valid&retire_dup -> dup+1. Saturate at 2**CNT_W-1, set track_err.
//   Dup retire when qed_num_dup==qed_num_orig (pre-update) sets track_err; dup still counted.
// - qed_check_valid (registered, from next-state values) = state TRACK & num_orig==num_dup &
//   num_orig!=0 & in-flight==0. Never asserted in the COMMIT cycle.
// - Latency: commit_req in IDLE with empty pipe -> sif_commit_pulsed 2 cycles later (DRAIN, COMMIT).
// - track_err cleared only by rst.
// TESTING
// - rst=1 2 cycles, then idle -> all outputs 0, sif_state=0.
// - commit_req at cycle 5, pipe empty -> sif_state 1 at 6, pulse+sif_commit at 7, state 3 at 8.
// - 3 issues, commit_req, retires at +2,+4,+6 -> fetch_hold high until in-flight 0; pulse cycle after last retire.
// - TRACK: retire orig,dup,orig,dup -> counts 1/0,1/1,2/1,2/2; qed_check_valid high after 2nd and 4th retire only.
// - TRACK: retire dup first -> track_err=1 sticky, qed_num_dup=1, qed_check_valid=0.
// - CNT_W=2: 4 orig retires -> qed_num_orig holds 3, track_err=1; rst mid-TRACK -> all 0, IDLE.

Source files
------------

// File: rtl/qed_sif_commit_tracker.sv
// QED commit-point tracker: drains the pipeline on request, marks T_C with a one-cycle pulse,
// then counts retired original/duplicate instructions and reports when the check is valid.
module qed_sif_commit_tracker #(
  parameter int CNT_W  = 8,
  parameter int INFL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit_req,
  input  logic             issue_valid,
  input  logic             retire_valid,
  input  logic             retire_dup,
  output logic             fetch_hold,
  output logic [1:0]       sif_state,
  output logic             sif_commit,
  output logic             sif_commit_pulsed,
  output logic [CNT_W-1:0] qed_num_orig,
  output logic [CNT_W-1:0] qed_num_dup,
  output logic             qed_check_valid,
  output logic             track_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    COMMIT = 2'd2,
    TRACK  = 2'd3
  } state_t;

  localparam logic [INFL_W-1:0] INFL_MAX = {INFL_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  state_t              state_r;
  state_t              state_nxt;
  logic [INFL_W-1:0]   infl_r;
  logic [INFL_W-1:0]   infl_nxt;
  logic                infl_err;
  logic [CNT_W-1:0]    orig_r;
  logic [CNT_W-1:0]    orig_nxt;
  logic [CNT_W-1:0]    dup_r;
  logic [CNT_W-1:0]    dup_nxt;
  logic                cnt_err;
  logic                fetch_hold_r;
  logic                commit_r;
  logic                pulse_r;
  logic                check_valid_r;
  logic                track_err_r;

  // In-flight counter; overflow/underflow hold the count and flag an error.
  always_comb begin
    infl_nxt = infl_r;
    infl_err = 1'b0;
    if (issue_valid && !retire_valid) begin
      if (infl_r == INFL_MAX) begin
        infl_err = 1'b1;
      end else begin
        infl_nxt = infl_r + {{(INFL_W-1){1'b0}}, 1'b1};
      end
    end else if (retire_valid && !issue_valid) begin
      if (infl_r == {INFL_W{1'b0}}) begin
        infl_err = 1'b1;
      end else begin
        infl_nxt = infl_r - {{(INFL_W-1){1'b0}}, 1'b1};
      end
    end else begin
      infl_nxt = infl_r;
    end
  end

  // Drain uses the post-update count so a retire that empties the pipe commits immediately.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (commit_req) begin
          state_nxt = DRAIN;
        end else begin
          state_nxt = IDLE;
        end
      end
      DRAIN: begin
        if (infl_nxt == {INFL_W{1'b0}}) begin
          state_nxt = COMMIT;
        end else begin
          state_nxt = DRAIN;
        end
      end
      COMMIT:  state_nxt = TRACK;
      TRACK:   state_nxt = TRACK;
      default: state_nxt = IDLE;
    endcase
  end

  // Retire counting is active only in TRACK; a duplicate overtaking its original is an error.
  always_comb begin
    orig_nxt = orig_r;
    dup_nxt  = dup_r;
    cnt_err  = 1'b0;
    if (state_nxt == COMMIT) begin
      orig_nxt = {CNT_W{1'b0}};
      dup_nxt  = {CNT_W{1'b0}};
    end else if ((state_r == TRACK) && retire_valid) begin
      if (retire_dup) begin
        if (dup_r == orig_r) begin
          cnt_err = 1'b1;
        end else begin
          cnt_err = 1'b0;
        end
        if (dup_r == CNT_MAX) begin
          cnt_err = 1'b1;
        end else begin
          dup_nxt = dup_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        if (orig_r == CNT_MAX) begin
          cnt_err = 1'b1;
        end else begin
          orig_nxt = orig_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end else begin
      orig_nxt = orig_r;
      dup_nxt  = dup_r;
    end
  end

  // State, counters and registered outputs (all decoded from next-state values).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      infl_r        <= {INFL_W{1'b0}};
      orig_r        <= {CNT_W{1'b0}};
      dup_r         <= {CNT_W{1'b0}};
      fetch_hold_r  <= 1'b0;
      commit_r      <= 1'b0;
      pulse_r       <= 1'b0;
      check_valid_r <= 1'b0;
      track_err_r   <= 1'b0;
    end else begin
      state_r       <= state_nxt;
      infl_r        <= infl_nxt;
      orig_r        <= orig_nxt;
      dup_r         <= dup_nxt;
      fetch_hold_r  <= (state_nxt == DRAIN);
      commit_r      <= (state_nxt == COMMIT) || (state_nxt == TRACK);
      pulse_r       <= (state_nxt == COMMIT);
      check_valid_r <= (state_nxt == TRACK) && (orig_nxt == dup_nxt) &&
                       (orig_nxt != {CNT_W{1'b0}}) && (infl_nxt == {INFL_W{1'b0}});
      track_err_r   <= track_err_r | infl_err | cnt_err;
    end
  end

  assign sif_state         = state_r;
  assign fetch_hold        = fetch_hold_r;
  assign sif_commit        = commit_r;
  assign sif_commit_pulsed = pulse_r;
  assign qed_num_orig      = orig_r;
  assign qed_num_dup       = dup_r;
  assign qed_check_valid   = check_valid_r;
  assign track_err         = track_err_r;

endmodule

// File: tb/tb_qed_sif_commit_tracker.sv
// Directed bench for qed_sif_commit_tracker: default instance plus a CNT_W=2 instance for saturation.
module tb_qed_sif_commit_tracker;

  logic       clk;
  logic       rst;
  logic       commit_req;
  logic       issue_valid;
  logic       retire_valid;
  logic       retire_dup;

  logic       a_fetch_hold, a_commit, a_pulse, a_cv, a_err;
  logic [1:0] a_state;
  logic [7:0] a_orig, a_dup;

  logic       b_fetch_hold, b_commit, b_pulse, b_cv, b_err;
  logic [1:0] b_state;
  logic [1:0] b_orig, b_dup;

  int checks;
  int errors;

  qed_sif_commit_tracker #(.CNT_W(8), .INFL_W(4)) dut_a (
    .clk(clk), .rst(rst), .commit_req(commit_req), .issue_valid(issue_valid),
    .retire_valid(retire_valid), .retire_dup(retire_dup),
    .fetch_hold(a_fetch_hold), .sif_state(a_state), .sif_commit(a_commit),
    .sif_commit_pulsed(a_pulse), .qed_num_orig(a_orig), .qed_num_dup(a_dup),
    .qed_check_valid(a_cv), .track_err(a_err)
  );

  qed_sif_commit_tracker #(.CNT_W(2), .INFL_W(4)) dut_b (
    .clk(clk), .rst(rst), .commit_req(commit_req), .issue_valid(issue_valid),
    .retire_valid(retire_valid), .retire_dup(retire_dup),
    .fetch_hold(b_fetch_hold), .sif_state(b_state), .sif_commit(b_commit),
    .sif_commit_pulsed(b_pulse), .qed_num_orig(b_orig), .qed_num_dup(b_dup),
    .qed_check_valid(b_cv), .track_err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; commit_req = 1'b0; issue_valid = 1'b0; retire_valid = 1'b0; retire_dup = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic enter_track();
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    tick();
    tick();
  endtask

  // Issue and retire together so the in-flight count stays at zero.
  task automatic retire_one(input logic dup);
    issue_valid = 1'b1; retire_valid = 1'b1; retire_dup = dup;
    tick();
    issue_valid = 1'b0; retire_valid = 1'b0; retire_dup = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    checks++; if (a_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", a_state); end
    checks++; if ({a_fetch_hold, a_commit, a_pulse, a_cv, a_err} !== 5'b00000) begin
      errors++; $display("FAIL reset_flags got %b exp 00000", {a_fetch_hold, a_commit, a_pulse, a_cv, a_err}); end
    checks++; if ({a_orig, a_dup} !== 16'h0000) begin
      errors++; $display("FAIL reset_counts got %h exp 0000", {a_orig, a_dup}); end
  endtask

  task automatic test_latency();
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    checks++; if (a_state !== 2'd1 || a_fetch_hold !== 1'b1 || a_pulse !== 1'b0) begin
      errors++; $display("FAIL lat_drain state %0d hold %b pulse %b exp 1 1 0", a_state, a_fetch_hold, a_pulse); end
    tick();
    checks++; if (a_state !== 2'd2 || a_pulse !== 1'b1 || a_commit !== 1'b1 || a_fetch_hold !== 1'b0) begin
      errors++; $display("FAIL lat_commit state %0d pulse %b commit %b hold %b exp 2 1 1 0",
                         a_state, a_pulse, a_commit, a_fetch_hold); end
    checks++; if (a_cv !== 1'b0 || a_orig !== 8'd0) begin
      errors++; $display("FAIL lat_commit_cv cv %b orig %0d exp 0 0", a_cv, a_orig); end
    tick();
    checks++; if (a_state !== 2'd3 || a_pulse !== 1'b0 || a_commit !== 1'b1) begin
      errors++; $display("FAIL lat_track state %0d pulse %b commit %b exp 3 0 1", a_state, a_pulse, a_commit); end
  endtask

  task automatic test_drain();
    do_reset();
    issue_valid = 1'b1;
    repeat (3) tick();
    issue_valid = 1'b0;
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    checks++; if (a_state !== 2'd1) begin errors++; $display("FAIL drain_enter got %0d exp 1", a_state); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (a_fetch_hold !== 1'b1) begin
        errors++; $display("FAIL drain_hold_%0d got %b exp 1", k, a_fetch_hold); end
      retire_valid = 1'b1;
      tick();
      retire_valid = 1'b0;
      if (k < 2) begin
        checks++; if (a_state !== 2'd1 || a_pulse !== 1'b0) begin
          errors++; $display("FAIL drain_wait_%0d state %0d pulse %b exp 1 0", k, a_state, a_pulse); end
      end else begin
        checks++; if (a_state !== 2'd2 || a_pulse !== 1'b1 || a_fetch_hold !== 1'b0) begin
          errors++; $display("FAIL drain_commit state %0d pulse %b hold %b exp 2 1 0", a_state, a_pulse, a_fetch_hold); end
      end
    end
    tick();
    checks++; if (a_state !== 2'd3 || a_err !== 1'b0) begin
      errors++; $display("FAIL drain_track state %0d err %b exp 3 0", a_state, a_err); end
  endtask

  task automatic test_counting();
    logic [3:0] dups;
    logic [3:0] exp_cv;
    logic [7:0] exp_o [4];
    logic [7:0] exp_d [4];
    dups = 4'b1010; exp_cv = 4'b1010;
    exp_o[0] = 8'd1; exp_o[1] = 8'd1; exp_o[2] = 8'd2; exp_o[3] = 8'd2;
    exp_d[0] = 8'd0; exp_d[1] = 8'd1; exp_d[2] = 8'd1; exp_d[3] = 8'd2;
    do_reset();
    enter_track();
    for (int k = 0; k < 4; k++) begin
      retire_one(dups[k]);
      checks++; if (a_orig !== exp_o[k] || a_dup !== exp_d[k] || a_cv !== exp_cv[k]) begin
        errors++; $display("FAIL count_%0d got %0d/%0d cv %b exp %0d/%0d cv %b",
                           k, a_orig, a_dup, a_cv, exp_o[k], exp_d[k], exp_cv[k]); end
    end
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    checks++; if (a_state !== 2'd3 || a_pulse !== 1'b0 || a_err !== 1'b0) begin
      errors++; $display("FAIL track_ignore_req state %0d pulse %b err %b exp 3 0 0", a_state, a_pulse, a_err); end
  endtask

  task automatic test_dup_first();
    do_reset();
    enter_track();
    retire_one(1'b1);
    checks++; if (a_dup !== 8'd1 || a_orig !== 8'd0 || a_err !== 1'b1 || a_cv !== 1'b0) begin
      errors++; $display("FAIL dup_first dup %0d orig %0d err %b cv %b exp 1 0 1 0", a_dup, a_orig, a_err, a_cv); end
    retire_one(1'b0);
    checks++; if (a_err !== 1'b1 || a_orig !== 8'd1) begin
      errors++; $display("FAIL dup_sticky err %b orig %0d exp 1 1", a_err, a_orig); end
  endtask

  task automatic test_underflow();
    do_reset();
    retire_valid = 1'b1;
    tick();
    retire_valid = 1'b0;
    checks++; if (a_err !== 1'b1 || a_orig !== 8'd0 || a_state !== 2'd0) begin
      errors++; $display("FAIL underflow err %b orig %0d state %0d exp 1 0 0", a_err, a_orig, a_state); end
  endtask

  task automatic test_saturate();
    do_reset();
    enter_track();
    repeat (4) retire_one(1'b0);
    checks++; if (b_orig !== 2'd3 || b_err !== 1'b1) begin
      errors++; $display("FAIL sat_narrow orig %0d err %b exp 3 1", b_orig, b_err); end
    checks++; if (a_orig !== 8'd4 || a_err !== 1'b0) begin
      errors++; $display("FAIL sat_wide orig %0d err %b exp 4 0", a_orig, a_err); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (a_state !== 2'd0 || a_commit !== 1'b0 || a_orig !== 8'd0 || a_err !== 1'b0) begin
      errors++; $display("FAIL midreset_a state %0d commit %b orig %0d err %b exp 0 0 0 0",
                         a_state, a_commit, a_orig, a_err); end
    checks++; if (b_state !== 2'd0 || b_orig !== 2'd0 || b_err !== 1'b0) begin
      errors++; $display("FAIL midreset_b state %0d orig %0d err %b exp 0 0 0", b_state, b_orig, b_err); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_latency();
    test_drain();
    test_counting();
    test_dup_first();
    test_underflow();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
